pc_ctrl: RTL

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
// Fetch-address controller: sequential IP advance, stall-then-redirect for JAL/JALR/BRANCH.
// Optional macro PC_JALR_ABS_EN selects the absolute JALR target (jalr_base + up_amt, bit 0 cleared).
module pc_ctrl #(
   parameter int unsigned      XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_VEC = '0,
   parameter int unsigned      BR_STALL  = 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [6:0]      OP,
   input  logic            b_taken,
   input  logic [XLEN-1:0] up_amt,
   input  logic [XLEN-1:0] jalr_base,
   input  logic            hold,
   output logic [XLEN-1:0] IP,
   output logic [XLEN-1:0] PC_def,
   output logic            stalled,
   output logic            redir,
   output logic            misalign
);

   localparam int unsigned CNT_W     = $clog2(BR_STALL) + 1;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      CLS_JAL    = 2'd0,
      CLS_JALR   = 2'd1,
      CLS_BRANCH = 2'd2
   } cls_t;

   state_t            state_q, state_d;
   cls_t              cls_q, cls_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   ip_q, ip_d;
   logic              redir_q, redir_d;
   logic              misalign_q, misalign_d;

   logic              is_ctrl;
   cls_t              op_cls;
   logic [XLEN-1:0]   ip_seq;
   logic [XLEN-1:0]   rel_target;
   logic [XLEN-1:0]   jalr_target;
   logic [XLEN-1:0]   target;
   logic              taken;

   // Opcode decode for the instruction at IP
   always_comb begin
      is_ctrl = 1'b0;
      op_cls  = CLS_BRANCH;
      if (OP == OP_JAL) begin
         is_ctrl = 1'b1;
         op_cls  = CLS_JAL;
      end else if (OP == OP_JALR) begin
         is_ctrl = 1'b1;
         op_cls  = CLS_JALR;
      end else if (OP == OP_BRANCH) begin
         is_ctrl = 1'b1;
         op_cls  = CLS_BRANCH;
      end
   end

   assign ip_seq     = ip_q + XLEN'(4);
   assign rel_target = ip_q + up_amt;

`ifdef PC_JALR_ABS_EN
   assign jalr_target = (jalr_base + up_amt) & ~XLEN'(1);
`else
   logic unused_jalr_base;
   assign unused_jalr_base = ^jalr_base;
   assign jalr_target      = rel_target;
`endif

   assign target = (cls_q == CLS_JALR) ? jalr_target : rel_target;
   assign taken  = (cls_q != CLS_BRANCH) || b_taken;

   // Next-state and register update logic
   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      cnt_d      = cnt_q;
      ip_d       = ip_q;
      redir_d    = 1'b0;
      misalign_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!hold) begin
               if (is_ctrl) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(BR_STALL - 1);
                  cls_d   = op_cls;
               end else begin
                  ip_d = ip_seq;
               end
            end
         end
         ST_WAIT: begin
            if (!hold) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = ST_RUN;
                  if (taken) begin
                     ip_d       = target;
                     redir_d    = 1'b1;
                     misalign_d = |target[1:0];
                  end else begin
                     ip_d = ip_seq;
                  end
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_RUN;
         cls_q      <= CLS_JAL;
         cnt_q      <= '0;
         ip_q       <= RESET_VEC;
         redir_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cls_q      <= cls_d;
         cnt_q      <= cnt_d;
         ip_q       <= ip_d;
         redir_q    <= redir_d;
         misalign_q <= misalign_d;
      end
   end

   assign IP       = ip_q;
   assign PC_def   = ip_seq;
   assign stalled  = (state_q == ST_WAIT);
   assign redir    = redir_q;
   assign misalign = misalign_q;

endmodule
